// File: rtl/mem_arbiter_nbank.sv
// mem_arbiter_nbank: arbitrates NUM_CLIENTS frame-buffer clients onto NUM_BANKS
// single-port SRAM banks. Each client owns a slot {bank, loc} that rotates on
// frame_flag. Reads are tagged through a per-bank READ_LATENCY pipeline so the
// returning data lands on the client that issued them, even across a rotation.
// Optional feature: define MEM_ARB_RR_EN for per-bank round-robin arbitration;
// without it each bank uses fixed priority (lowest client index wins).
module mem_arbiter_nbank #(
    parameter int NUM_CLIENTS  = 4,
    parameter int NUM_BANKS    = 2,
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 36,
    parameter int READ_LATENCY = 2,
    parameter int IMAGE_LEN    = 19200
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frame_flag,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        wr,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] offset,
    input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
    output logic [NUM_CLIENTS-1:0]        gnt,
    output logic [NUM_CLIENTS-1:0]        rvalid,
    output logic [NUM_CLIENTS*DATA_W-1:0] rdata,
    output logic [NUM_BANKS*ADDR_W-1:0]   mem_addr,
    output logic [NUM_BANKS*DATA_W-1:0]   mem_wdata,
    output logic [NUM_BANKS-1:0]          mem_wr,
    input  logic [NUM_BANKS*DATA_W-1:0]   mem_rdata
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int TAG_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int LOC_W  = TAG_W;
    localparam logic [ADDR_W-1:0] IMG_LEN = ADDR_W'(IMAGE_LEN);

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [LOC_W-1:0]  loc;
    } slot_t;

    slot_t             map_q [NUM_CLIENTS];
    slot_t             map_d [NUM_CLIENTS];
    logic [ADDR_W-1:0] cli_addr [NUM_CLIENTS];

    logic [NUM_BANKS-1:0] win_vld;
    logic [TAG_W-1:0]     win_idx [NUM_BANKS];

    logic [NUM_BANKS-1:0] push_vld_d;
    logic [TAG_W-1:0]     push_tag_d [NUM_BANKS];

    logic             pipe_vld_q [NUM_BANKS][READ_LATENCY];
    logic [TAG_W-1:0] pipe_tag_q [NUM_BANKS][READ_LATENCY];

    logic [NUM_CLIENTS*DATA_W-1:0] rdata_q;
    logic [NUM_CLIENTS*DATA_W-1:0] rdata_d;

`ifdef MEM_ARB_RR_EN
    logic [TAG_W-1:0] ptr_q [NUM_BANKS];
    logic [TAG_W-1:0] ptr_d [NUM_BANKS];
`endif

    // Per-client bank address: buffer base (loc * IMAGE_LEN) plus word offset, wrapping at ADDR_W.
    always_comb begin
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            cli_addr[c] = ADDR_W'(map_q[c].loc) * IMG_LEN + offset[c*ADDR_W +: ADDR_W];
        end
    end

    // Slot map next state: rotate every entry down by one client on a frame pulse.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        map_d = map_q;
        if (frame_flag) begin
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                map_d[c] = map_q[(c + 1) % NUM_CLIENTS];
            end
        end
    end

    // Slot map register; frame_flag is ignored while reset is held.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                map_q[c].bank <= BANK_W'(c % NUM_BANKS);
                map_q[c].loc  <= LOC_W'(c / NUM_BANKS);
            end
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            map_q <= map_d;
        end
    end

    // Per-bank winner selection among requesting clients currently mapped to that bank.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        int idx;
        idx = 0;
`endif
        win_vld = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            win_idx[b] = '0;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
`ifdef MEM_ARB_RR_EN
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                idx = int'(ptr_q[b]) + i;
                if (idx >= NUM_CLIENTS) begin
                    idx = idx - NUM_CLIENTS;
                end
                if (!win_vld[b] && req[idx] && (map_q[idx].bank == BANK_W'(b))) begin
                    win_vld[b] = 1'b1;
                    win_idx[b] = TAG_W'(idx);
                end
            end
`else
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                if (!win_vld[b] && req[c] && (map_q[c].bank == BANK_W'(b))) begin
                    win_vld[b] = 1'b1;
                    win_idx[b] = TAG_W'(c);
                end
            end
`endif
        end
        if (reset) begin
            win_vld = '0;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin pointer next state: one past the most recent winner on each bank.
    always_comb begin
        ptr_d = ptr_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (win_vld[b]) begin
                ptr_d[b] = (int'(win_idx[b]) == NUM_CLIENTS - 1) ? '0 : win_idx[b] + 1'b1;
            end
        end
    end

    // Round-robin pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                ptr_q[b] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Grants, bank drive (idle banks drive zero) and the read tag to push per bank.
    always_comb begin
        gnt        = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wr     = '0;
        push_vld_d = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            push_tag_d[b] = win_idx[b];
            if (win_vld[b]) begin
                gnt[win_idx[b]]                 = 1'b1;
                mem_addr[b*ADDR_W +: ADDR_W]    = cli_addr[win_idx[b]];
                mem_wdata[b*DATA_W +: DATA_W]   = wdata[win_idx[b]*DATA_W +: DATA_W];
                mem_wr[b]                       = wr[win_idx[b]];
                push_vld_d[b]                   = !wr[win_idx[b]];
            end
        end
    end

    // Read tag pipelines: one stage per cycle of bank read latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the tag pipeline is reset on purpose so in-flight reads are discarded; plain data storage would not need it.
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int s = 0; s < READ_LATENCY; s++) begin
                    pipe_vld_q[b][s] <= 1'b0;
                    pipe_tag_q[b][s] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                pipe_vld_q[b][0] <= push_vld_d[b];
                pipe_tag_q[b][0] <= push_tag_d[b];
                for (int s = 1; s < READ_LATENCY; s++) begin
                    pipe_vld_q[b][s] <= pipe_vld_q[b][s-1];
                    pipe_tag_q[b][s] <= pipe_tag_q[b][s-1];
                end
            end
        end
    end

    // Read return: a tag leaving the pipeline pulses rvalid and presents that bank's data.
    always_comb begin
        rvalid  = '0;
        rdata_d = rdata_q;
        if (!reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (pipe_vld_q[b][READ_LATENCY-1]) begin
                    rvalid[pipe_tag_q[b][READ_LATENCY-1]] = 1'b1;
                    rdata_d[pipe_tag_q[b][READ_LATENCY-1]*DATA_W +: DATA_W] =
                        mem_rdata[b*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read data holding register; returned data stays visible until the next return.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Returned data is visible in the same cycle as rvalid and held afterwards.
    assign rdata = rdata_d;

endmodule

// File: tb/tb_mem_arbiter_nbank.sv
// Directed testbench for mem_arbiter_nbank with default parameters. A simple
// two-cycle SRAM model returns {8'hB0 + bank, 9'b0, addr} so read data identifies
// both the bank and the address it came from.
module tb_mem_arbiter_nbank;

    localparam int NC = 4;
    localparam int NB = 2;
    localparam int AW = 19;
    localparam int DW = 36;

    logic              clock;
    logic              reset;
    logic              frame_flag;
    logic [NC-1:0]     req;
    logic [NC-1:0]     wr;
    logic [NC*AW-1:0]  offset;
    logic [NC*DW-1:0]  wdata;
    logic [NC-1:0]     gnt;
    logic [NC-1:0]     rvalid;
    logic [NC*DW-1:0]  rdata;
    logic [NB*AW-1:0]  mem_addr;
    logic [NB*DW-1:0]  mem_wdata;
    logic [NB-1:0]     mem_wr;
    logic [NB*DW-1:0]  mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter_nbank #(
        .NUM_CLIENTS (NC),
        .NUM_BANKS   (NB),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .READ_LATENCY(2),
        .IMAGE_LEN   (19200)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .frame_flag(frame_flag),
        .req       (req),
        .wr        (wr),
        .offset    (offset),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Two-cycle-latency SRAM model: data for the address seen two cycles ago.
    logic [AW-1:0] addr_h0 [NB];
    logic [AW-1:0] addr_h1 [NB];

    always @(posedge clock) begin
        for (int b = 0; b < NB; b++) begin
            addr_h0[b] <= mem_addr[b*AW +: AW];
            addr_h1[b] <= addr_h0[b];
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int b = 0; b < NB; b++) begin
            mem_rdata[b*DW +: DW] = {8'hB0 + 8'(b), 9'd0, addr_h1[b]};
        end
    end

    function automatic logic [AW-1:0] bank_addr(input int b);
        return mem_addr[b*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] bank_wdata(input int b);
        return mem_wdata[b*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] cli_rdata(input int c);
        return rdata[c*DW +: DW];
    endfunction

    task automatic clear_inputs();
        req        = '0;
        wr         = '0;
        offset     = '0;
        wdata      = '0;
        frame_flag = 1'b0;
    endtask

    task automatic set_req(input int c, input logic w, input logic [AW-1:0] off,
                           input logic [DW-1:0] d);
        req[c]            = 1'b1;
        wr[c]             = w;
        offset[c*AW +: AW] = off;
        wdata[c*DW +: DW]  = d;
    endtask

    // Leaves the bench at a negedge with reset just released.
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        req        = '1;
        wr         = '1;
        frame_flag = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_gnt: got %b want %b", gnt, 4'b0000);
        end
        n_cmp++;
        if (mem_wr !== 2'b00) begin
            n_err++;
            $display("FAIL reset_mem_wr: got %b want %b", mem_wr, 2'b00);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        clear_inputs();
        set_req(0, 1'b0, 19'd1, '0);
        #1;
        n_cmp++;
        if (rvalid !== 4'b0000 || rdata !== '0) begin
            n_err++;
            $display("FAIL reset_rvalid_rdata: got rvalid=%b rdata=%h want 0 and 0", rvalid, rdata);
        end
        // frame_flag during reset must not have rotated the map: client0 still on bank0
        n_cmp++;
        if (gnt !== 4'b0001 || bank_addr(0) !== 19'd1) begin
            n_err++;
            $display("FAIL reset_map: got gnt=%b addr0=%0d want 0001 and 1", gnt, bank_addr(0));
        end
    endtask

    task automatic test_read();
        apply_reset();
        set_req(0, 1'b0, 19'd5, '0);
        #1;
        n_cmp++;
        if (gnt !== 4'b0001 || bank_addr(0) !== 19'd5 || mem_wr !== 2'b00) begin
            n_err++;
            $display("FAIL read_issue: got gnt=%b addr0=%0d wr=%b want 0001 5 00",
                     gnt, bank_addr(0), mem_wr);
        end
        @(negedge clock);
        clear_inputs();
        #1;
        n_cmp++;
        if (rvalid !== 4'b0000) begin
            n_err++;
            $display("FAIL read_early: got rvalid=%b want 0000", rvalid);
        end
        @(negedge clock);
        #1;
        n_cmp++;
        if (rvalid !== 4'b0001 || cli_rdata(0) !== 36'hB00000005) begin
            n_err++;
            $display("FAIL read_return: got rvalid=%b rdata0=%h want 0001 b00000005",
                     rvalid, cli_rdata(0));
        end
        @(negedge clock);
        #1;
        n_cmp++;
        if (rvalid !== 4'b0000 || cli_rdata(0) !== 36'hB00000005) begin
            n_err++;
            $display("FAIL read_hold: got rvalid=%b rdata0=%h want 0000 b00000005",
                     rvalid, cli_rdata(0));
        end
    endtask

    task automatic test_write();
        apply_reset();
        set_req(2, 1'b1, 19'd3, 36'h123456789);
        #1;
        n_cmp++;
        if (gnt !== 4'b0100 || bank_addr(0) !== 19'd19203 || mem_wr !== 2'b01 ||
            bank_wdata(0) !== 36'h123456789) begin
            n_err++;
            $display("FAIL write_issue: got gnt=%b addr0=%0d wr=%b wdata0=%h want 0100 19203 01 123456789",
                     gnt, bank_addr(0), mem_wr, bank_wdata(0));
        end
        n_cmp++;
        if (bank_addr(1) !== 19'd0 || bank_wdata(1) !== 36'd0) begin
            n_err++;
            $display("FAIL write_idle_bank: got addr1=%0d wdata1=%h want 0 0",
                     bank_addr(1), bank_wdata(1));
        end
        @(negedge clock);
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (rvalid !== 4'b0000) begin
                n_err++;
                $display("FAIL write_no_rvalid: cycle %0d got rvalid=%b want 0000", i + 1, rvalid);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_priority();
        logic [NC-1:0] exp_gnt [3];
        logic [AW-1:0] exp_addr [3];
`ifdef MEM_ARB_RR_EN
        exp_gnt  = '{4'b0001, 4'b0100, 4'b0001};
        exp_addr = '{19'd10, 19'd19220, 19'd10};
`else
        exp_gnt  = '{4'b0001, 4'b0001, 4'b0001};
        exp_addr = '{19'd10, 19'd10, 19'd10};
`endif
        apply_reset();
        set_req(0, 1'b0, 19'd10, '0);
        set_req(2, 1'b0, 19'd20, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (gnt !== exp_gnt[i] || bank_addr(0) !== exp_addr[i]) begin
                n_err++;
                $display("FAIL priority_cycle%0d: got gnt=%b addr0=%0d want %b %0d",
                         i, gnt, bank_addr(0), exp_gnt[i], exp_addr[i]);
            end
            @(negedge clock);
        end
        clear_inputs();
    endtask

    task automatic test_parallel();
        apply_reset();
        set_req(0, 1'b0, 19'd7, '0);
        set_req(1, 1'b0, 19'd8, '0);
        set_req(3, 1'b0, 19'd2, '0);
        #1;
        n_cmp++;
        if (gnt !== 4'b0011 || bank_addr(0) !== 19'd7 || bank_addr(1) !== 19'd8) begin
            n_err++;
            $display("FAIL parallel: got gnt=%b addr0=%0d addr1=%0d want 0011 7 8",
                     gnt, bank_addr(0), bank_addr(1));
        end
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_rotate();
        apply_reset();
        frame_flag = 1'b1;
        @(negedge clock);
        frame_flag = 1'b0;
        set_req(0, 1'b0, 19'd0, '0);
        #1;
        n_cmp++;
        if (gnt !== 4'b0001 || bank_addr(1) !== 19'd0) begin
            n_err++;
            $display("FAIL rotate1_c0: got gnt=%b addr1=%0d want 0001 0", gnt, bank_addr(1));
        end
        @(negedge clock);
        clear_inputs();
        set_req(0, 1'b0, 19'd6, '0);
        set_req(3, 1'b0, 19'd1, '0);
        #1;
        n_cmp++;
        if (gnt !== 4'b1001 || bank_addr(1) !== 19'd6 || bank_addr(0) !== 19'd1) begin
            n_err++;
            $display("FAIL rotate1_map: got gnt=%b addr1=%0d addr0=%0d want 1001 6 1",
                     gnt, bank_addr(1), bank_addr(0));
        end
        @(negedge clock);
        clear_inputs();
        for (int p = 0; p < 3; p++) begin
            frame_flag = 1'b1;
            @(negedge clock);
            frame_flag = 1'b0;
            @(negedge clock);
        end
        set_req(0, 1'b0, 19'd6, '0);
        set_req(1, 1'b0, 19'd2, '0);
        set_req(2, 1'b0, 19'd3, '0);
        #1;
        n_cmp++;
        if (gnt !== 4'b0011 || bank_addr(0) !== 19'd6 || bank_addr(1) !== 19'd2) begin
            n_err++;
            $display("FAIL rotate4_restore: got gnt=%b addr0=%0d addr1=%0d want 0011 6 2",
                     gnt, bank_addr(0), bank_addr(1));
        end
        @(negedge clock);
        req[0] = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 4'b0110 || bank_addr(0) !== 19'd19203 || bank_addr(1) !== 19'd2) begin
            n_err++;
            $display("FAIL rotate4_c2: got gnt=%b addr0=%0d addr1=%0d want 0110 19203 2",
                     gnt, bank_addr(0), bank_addr(1));
        end
        @(negedge clock);
        clear_inputs();
    endtask

    task automatic test_inflight();
        apply_reset();
        set_req(1, 1'b0, 19'd9, '0);
        #1;
        n_cmp++;
        if (gnt !== 4'b0010 || bank_addr(1) !== 19'd9) begin
            n_err++;
            $display("FAIL inflight_issue: got gnt=%b addr1=%0d want 0010 9", gnt, bank_addr(1));
        end
        @(negedge clock);
        // frame_flag cycle: grant still uses the pre-rotation map (bank1, loc0)
        frame_flag = 1'b1;
        set_req(1, 1'b0, 19'd11, '0);
        #1;
        n_cmp++;
        if (gnt !== 4'b0010 || bank_addr(1) !== 19'd11 || rvalid !== 4'b0000) begin
            n_err++;
            $display("FAIL inflight_flag_cycle: got gnt=%b addr1=%0d rvalid=%b want 0010 11 0000",
                     gnt, bank_addr(1), rvalid);
        end
        @(negedge clock);
        clear_inputs();
        #1;
        n_cmp++;
        if (rvalid !== 4'b0010 || cli_rdata(1) !== 36'hB10000009) begin
            n_err++;
            $display("FAIL inflight_return1: got rvalid=%b rdata1=%h want 0010 b10000009",
                     rvalid, cli_rdata(1));
        end
        @(negedge clock);
        #1;
        n_cmp++;
        if (rvalid !== 4'b0010 || cli_rdata(1) !== 36'hB1000000B) begin
            n_err++;
            $display("FAIL inflight_return2: got rvalid=%b rdata1=%h want 0010 b1000000b",
                     rvalid, cli_rdata(1));
        end
        @(negedge clock);
    endtask

    // Starts from the state left by test_inflight (rdata[1] nonzero).
    task automatic test_reset_flush();
        logic seen;
        seen = 1'b0;
        set_req(0, 1'b0, 19'd5, '0);
        #1;
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL flush_issue: got gnt=%b want 0001", gnt);
        end
        @(negedge clock);
        clear_inputs();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rvalid !== 4'b0000) begin
                seen = 1'b1;
            end
            @(negedge clock);
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL flush_rvalid: got a read return after reset want none");
        end
        n_cmp++;
        if (rdata !== '0) begin
            n_err++;
            $display("FAIL flush_rdata: got %h want 0", rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_read();
        test_write();
        test_priority();
        test_parallel();
        test_rotate();
        test_inflight();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_nbank.md
MEM_ARBITER_NBANK -- requirements
Module: mem_arbiter_nbank

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 4, number of requesting clients; one frame-buffer role per client.
REQ-002 SHALL have parameter NUM_BANKS, default 2, number of independent single-port SRAM banks.
REQ-003 SHALL have parameter ADDR_W, default 19, bank address width.
REQ-004 SHALL have parameter DATA_W, default 36, bank data width.
REQ-005 SHALL have parameter READ_LATENCY, default 2, cycles from bank address to valid mem_rdata; range 1..8.
REQ-006 SHALL have parameter IMAGE_LEN, default 19200, words per frame buffer.
REQ-007 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-009 SHALL have port frame_flag, input, 1, one-cycle pulse that rotates buffer roles.
REQ-010 SHALL have ports req/wr, input, NUM_CLIENTS, per-client access request and write-not-read.
REQ-011 SHALL have ports offset, input, NUM_CLIENTS*ADDR_W, and wdata, input, NUM_CLIENTS*DATA_W, per-client word offset within its buffer and write data.
REQ-012 SHALL have ports gnt and rvalid, output, NUM_CLIENTS, and rdata, output, NUM_CLIENTS*DATA_W.
REQ-013 SHALL have ports mem_addr, output, NUM_BANKS*ADDR_W; mem_wdata, output, NUM_BANKS*DATA_W; mem_wr, output, NUM_BANKS; mem_rdata, input, NUM_BANKS*DATA_W.

Function
REQ-014 SHALL keep a slot map of NUM_CLIENTS entries {bank, loc}; client c uses slot map[c].
REQ-015 SHALL, on frame_flag, load map[c] <= map[(c+1) mod NUM_CLIENTS] for all c, effective the following cycle.
REQ-016 SHALL compute a client's address as loc*IMAGE_LEN + offset, truncated to ADDR_W.
REQ-017 SHALL arbitrate each bank independently among clients with req=1 whose slot maps to that bank; at most one grant per bank per cycle.
REQ-018 SHALL assert gnt combinationally in the same cycle as the winning req; a non-granted client holds req and retries.
REQ-019 SHALL drive the granted client's address, wdata and wr onto the bank; an idle bank drives mem_addr=0, mem_wdata=0, mem_wr=0.
REQ-020 SHALL push a client tag into a per-bank READ_LATENCY-deep shift pipeline on every granted read; writes and idle cycles push "none".
REQ-021 SHALL, when a tag exits the pipeline, pulse rvalid[tag] for one cycle and register mem_rdata into rdata[tag]; rdata otherwise holds its last value.
REQ-022 SHALL use the pre-rotation map for grants in a frame_flag cycle; in-flight reads complete to their original client regardless of rotation.
REQ-023 SHALL give gnt=0 to a client whose slot's bank has a higher-priority winner; no request is dropped or queued internally.
REQ-024 SHALL allow two clients on different banks to be granted in the same cycle.

Reset
REQ-025 SHALL, on reset, set map[c] = {bank = c mod NUM_BANKS, loc = c / NUM_BANKS}.
REQ-026 SHALL, on reset, clear all read pipelines to "none", rvalid=0, rdata=0; in-flight reads are discarded.
REQ-027 SHALL, while reset=1, force gnt=0 and all mem_wr=0; frame_flag is ignored.

Configuration
REQ-028 SHALL, with macro MEM_ARB_RR_EN defined, use per-bank round-robin: pointer starts at 0 on reset, after a grant to client k the pointer becomes (k+1) mod NUM_CLIENTS, search begins at the pointer.
REQ-029 SHALL, without MEM_ARB_RR_EN, use fixed priority, lowest client index highest, and contain no pointer state.

Verification
REQ-030 SHALL test: reset released, client0 reads offset 5 (bank0, loc0) -> mem_addr[0]=5, gnt[0]=1, rvalid[0] exactly 2 cycles later with rdata[0]=bank0 data.
REQ-031 SHALL test: client2 writes offset 3 -> bank0 mem_addr=19203, mem_wr[0]=1, no rvalid for client2.
REQ-032 SHALL test: clients 0 and 2 request same cycle, fixed priority -> gnt=4'b0001; with MEM_ARB_RR_EN, three consecutive cycles -> gnt 0001, 0100, 0001.
REQ-033 SHALL test: one frame_flag pulse -> client0 then uses bank1 loc0 (offset 0 -> mem_addr[1]=0); four pulses restore the initial map.
REQ-034 SHALL test: client1 read granted, frame_flag next cycle -> rvalid[1] still fires at latency 2 with bank1 data.
REQ-035 SHALL test: reset asserted one cycle after a granted read -> no rvalid ever fires for that read, rdata all zero.
